// File: rtl/cpu_pkg.sv
// Shared types and widths for the 5-stage RISC-V core pipeline.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int ALU_OP_W   = 2;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_2_reg;
        logic alu_src;
        logic branch;
        logic jump;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_exe_stage_load_use_detect.sv
// Combinational load-use hazard check between ID and the load sitting in ID/EXE.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  valid_ex_i,
    input  logic                  mem_read_ex_i,
    input  logic [REG_ADDR_W-1:0] rd_ex_i,
    input  logic                  valid_id_i,
    input  logic                  use_rs1_i,
    input  logic                  use_rs2_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic                  load_use_o
);

    logic rd_live;
    logic hit_rs1;
    logic hit_rs2;

    // x0 is hardwired zero, so a load to it never creates a dependency
    assign rd_live = valid_ex_i & mem_read_ex_i & (rd_ex_i != '0);
    assign hit_rs1 = use_rs1_i & (rs1_i == rd_ex_i);
    assign hit_rs2 = use_rs2_i & (rs2_i == rd_ex_i);

    assign load_use_o = rd_live & valid_id_i & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with load-use bubble insertion and flush squash.
// Optional perf counters (stall_cnt, flush_cnt) enabled by ID_EXE_PERF_CNT_EN.
module id_exe_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2
`ifdef ID_EXE_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  logic                  flush,
    input  logic                  valid_ID,
    input  logic                  use_rs1_ID,
    input  logic                  use_rs2_ID,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic [REG_ADDR_W-1:0] rd_ID,
    input  logic [DATA_W-1:0]     rdata1_ID,
    input  logic [DATA_W-1:0]     rdata2_ID,
    input  logic [DATA_W-1:0]     imm_ID,
    input  logic [DATA_W-1:0]     pc_ID,
    input  logic                  reg_write_ID,
    input  logic                  mem_read_ID,
    input  logic                  mem_write_ID,
    input  logic                  mem_2_reg_ID,
    input  logic                  alu_src_ID,
    input  logic                  branch_ID,
    input  logic                  jump_ID,
    input  logic [ALU_OP_W-1:0]   alu_op_ID,
    output logic                  stall_IF_ID,
    output logic                  valid_ID_EXE,
    output logic [REG_ADDR_W-1:0] Rs1_ID_EXE,
    output logic [REG_ADDR_W-1:0] Rs2_ID_EXE,
    output logic [REG_ADDR_W-1:0] Rd_ID_EXE,
    output logic [DATA_W-1:0]     rdata1_ID_EXE,
    output logic [DATA_W-1:0]     rdata2_ID_EXE,
    output logic [DATA_W-1:0]     imm_ID_EXE,
    output logic [DATA_W-1:0]     pc_ID_EXE,
    output logic                  reg_write_ID_EXE,
    output logic                  mem_read_ID_EXE,
    output logic                  mem_write_ID_EXE,
    output logic                  mem_2_reg_ID_EXE,
    output logic                  alu_src_ID_EXE,
    output logic                  branch_ID_EXE,
    output logic                  jump_ID_EXE,
    output logic [ALU_OP_W-1:0]   alu_op_ID_EXE
`ifdef ID_EXE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    import cpu_pkg::*;

    logic                  load_use;
    ctrl_t                 ctrl_in;
    ctrl_t                 ctrl_q, ctrl_d;
    logic                  valid_q, valid_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     rdata1_q, rdata1_d;
    logic [DATA_W-1:0]     rdata2_q, rdata2_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [DATA_W-1:0]     pc_q, pc_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;

    assign ctrl_in = '{
        reg_write: reg_write_ID,
        mem_read:  mem_read_ID,
        mem_write: mem_write_ID,
        mem_2_reg: mem_2_reg_ID,
        alu_src:   alu_src_ID,
        branch:    branch_ID,
        jump:      jump_ID
    };

    load_use_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use_detect (
        .valid_ex_i    (valid_q),
        .mem_read_ex_i (ctrl_q.mem_read),
        .rd_ex_i       (rd_q),
        .valid_id_i    (valid_ID),
        .use_rs1_i     (use_rs1_ID),
        .use_rs2_i     (use_rs2_ID),
        .rs1_i         (rs1_ID),
        .rs2_i         (rs2_ID),
        .load_use_o    (load_use)
    );

    // IF/ID is squashed on flush, so holding it would be pointless
    assign stall_IF_ID = load_use & ~flush & ~rst;

    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        alu_op_d = alu_op_q;
        if (hold) begin
            valid_d = valid_q;
        end else if (flush || load_use) begin
            // Rd cleared so forwarding can never match a bubble
            valid_d = 1'b0;
            ctrl_d  = CTRL_BUBBLE;
            rd_d    = '0;
        end else begin
            valid_d  = valid_ID;
            ctrl_d   = ctrl_in;
            rs1_d    = rs1_ID;
            rs2_d    = rs2_ID;
            rd_d     = rd_ID;
            rdata1_d = rdata1_ID;
            rdata2_d = rdata2_ID;
            imm_d    = imm_ID;
            pc_d     = pc_ID;
            alu_op_d = alu_op_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            ctrl_q   <= CTRL_BUBBLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            alu_op_q <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            alu_op_q <= alu_op_d;
        end
    end

    assign valid_ID_EXE     = valid_q;
    assign Rs1_ID_EXE       = rs1_q;
    assign Rs2_ID_EXE       = rs2_q;
    assign Rd_ID_EXE        = rd_q;
    assign rdata1_ID_EXE    = rdata1_q;
    assign rdata2_ID_EXE    = rdata2_q;
    assign imm_ID_EXE       = imm_q;
    assign pc_ID_EXE        = pc_q;
    assign reg_write_ID_EXE = ctrl_q.reg_write;
    assign mem_read_ID_EXE  = ctrl_q.mem_read;
    assign mem_write_ID_EXE = ctrl_q.mem_write;
    assign mem_2_reg_ID_EXE = ctrl_q.mem_2_reg;
    assign alu_src_ID_EXE   = ctrl_q.alu_src;
    assign branch_ID_EXE    = ctrl_q.branch;
    assign jump_ID_EXE      = ctrl_q.jump;
    assign alu_op_ID_EXE    = alu_op_q;

`ifdef ID_EXE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_IF_ID && !hold) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && !hold) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_exe_stage.sv
// Self-checking bench for id_exe_stage: cycle vectors plus scoreboard queue.
module tb_id_exe_stage;

    logic        clk = 1'b0;
    logic        rst, hold, flush, valid_ID, use_rs1_ID, use_rs2_ID;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic [31:0] rdata1_ID, rdata2_ID, imm_ID, pc_ID;
    logic        reg_write_ID, mem_read_ID, mem_write_ID, mem_2_reg_ID;
    logic        alu_src_ID, branch_ID, jump_ID;
    logic [1:0]  alu_op_ID;
    logic        stall_IF_ID, valid_ID_EXE;
    logic [4:0]  Rs1_ID_EXE, Rs2_ID_EXE, Rd_ID_EXE;
    logic [31:0] rdata1_ID_EXE, rdata2_ID_EXE, imm_ID_EXE, pc_ID_EXE;
    logic        reg_write_ID_EXE, mem_read_ID_EXE, mem_write_ID_EXE;
    logic        mem_2_reg_ID_EXE, alu_src_ID_EXE, branch_ID_EXE, jump_ID_EXE;
    logic [1:0]  alu_op_ID_EXE;
`ifdef ID_EXE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    id_exe_stage dut (
        .clk              (clk),
        .rst              (rst),
        .hold             (hold),
        .flush            (flush),
        .valid_ID         (valid_ID),
        .use_rs1_ID       (use_rs1_ID),
        .use_rs2_ID       (use_rs2_ID),
        .rs1_ID           (rs1_ID),
        .rs2_ID           (rs2_ID),
        .rd_ID            (rd_ID),
        .rdata1_ID        (rdata1_ID),
        .rdata2_ID        (rdata2_ID),
        .imm_ID           (imm_ID),
        .pc_ID            (pc_ID),
        .reg_write_ID     (reg_write_ID),
        .mem_read_ID      (mem_read_ID),
        .mem_write_ID     (mem_write_ID),
        .mem_2_reg_ID     (mem_2_reg_ID),
        .alu_src_ID       (alu_src_ID),
        .branch_ID        (branch_ID),
        .jump_ID          (jump_ID),
        .alu_op_ID        (alu_op_ID),
        .stall_IF_ID      (stall_IF_ID),
        .valid_ID_EXE     (valid_ID_EXE),
        .Rs1_ID_EXE       (Rs1_ID_EXE),
        .Rs2_ID_EXE       (Rs2_ID_EXE),
        .Rd_ID_EXE        (Rd_ID_EXE),
        .rdata1_ID_EXE    (rdata1_ID_EXE),
        .rdata2_ID_EXE    (rdata2_ID_EXE),
        .imm_ID_EXE       (imm_ID_EXE),
        .pc_ID_EXE        (pc_ID_EXE),
        .reg_write_ID_EXE (reg_write_ID_EXE),
        .mem_read_ID_EXE  (mem_read_ID_EXE),
        .mem_write_ID_EXE (mem_write_ID_EXE),
        .mem_2_reg_ID_EXE (mem_2_reg_ID_EXE),
        .alu_src_ID_EXE   (alu_src_ID_EXE),
        .branch_ID_EXE    (branch_ID_EXE),
        .jump_ID_EXE      (jump_ID_EXE),
        .alu_op_ID_EXE    (alu_op_ID_EXE)
`ifdef ID_EXE_PERF_CNT_EN
        ,
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
`endif
    );

    typedef struct {
        logic        rst, hold, flush, valid, mr, rw, u1, u2;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  misc;
        logic [31:0] pc;
        logic        e_stall, e_valid, e_rw, e_mr, e_asrc;
        logic [4:0]  e_rd, e_rs1, e_rs2;
        logic [2:0]  e_misc;
        logic [31:0] e_pc;
        int          e_sc, e_fc;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tv[$];

    function automatic vec_t lw(input logic [4:0] rd, input logic [31:0] pc);
        vec_t v;
        v = '{default: 0};
        v.valid = 1'b1; v.mr = 1'b1; v.rw = 1'b1;
        v.u1 = 1'b1; v.rs1 = 5'd2; v.rd = rd; v.pc = pc;
        return v;
    endfunction

    function automatic vec_t op(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic u2,
                                input logic rw, input logic [2:0] misc,
                                input logic [31:0] pc);
        vec_t v;
        v = '{default: 0};
        v.valid = 1'b1; v.u1 = 1'b1; v.u2 = u2; v.rw = rw;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.misc = misc; v.pc = pc;
        return v;
    endfunction

    function automatic vec_t ctl(input vec_t v, input logic r, input logic h,
                                 input logic f, input logic vl);
        vec_t o;
        o = v;
        o.rst = r; o.hold = h; o.flush = f; o.valid = vl;
        return o;
    endfunction

    function automatic vec_t cap(input vec_t v, input logic st, input int sc, input int fc);
        vec_t o;
        o = v;
        o.e_stall = st; o.e_valid = v.valid; o.e_rw = v.rw; o.e_mr = v.mr;
        o.e_asrc = ~v.u2; o.e_rd = v.rd; o.e_rs1 = v.rs1; o.e_rs2 = v.rs2;
        o.e_misc = v.misc; o.e_pc = v.pc; o.e_sc = sc; o.e_fc = fc;
        return o;
    endfunction

    function automatic vec_t bub(input vec_t v, input logic st, input int sc, input int fc);
        vec_t o;
        o = v;
        o.e_stall = st; o.e_valid = 1'b0; o.e_rw = 1'b0; o.e_mr = 1'b0;
        o.e_asrc = 1'b0; o.e_rd = '0; o.e_rs1 = '0; o.e_rs2 = '0;
        o.e_misc = '0; o.e_pc = '0; o.e_sc = sc; o.e_fc = fc;
        return o;
    endfunction

    function automatic vec_t frz(input vec_t v, input vec_t p, input logic st,
                                 input int sc, input int fc);
        vec_t o;
        o = p;
        o.rst = v.rst; o.hold = v.hold; o.flush = v.flush; o.valid = v.valid;
        o.mr = v.mr; o.rw = v.rw; o.u1 = v.u1; o.u2 = v.u2;
        o.rs1 = v.rs1; o.rs2 = v.rs2; o.rd = v.rd; o.misc = v.misc; o.pc = v.pc;
        o.e_stall = st; o.e_sc = sc; o.e_fc = fc;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        rst = v.rst; hold = v.hold; flush = v.flush; valid_ID = v.valid;
        mem_read_ID = v.mr; mem_2_reg_ID = v.mr; reg_write_ID = v.rw;
        use_rs1_ID = v.u1; use_rs2_ID = v.u2; alu_src_ID = ~v.u2;
        rs1_ID = v.rs1; rs2_ID = v.rs2; rd_ID = v.rd;
        {mem_write_ID, branch_ID, jump_ID} = v.misc;
        pc_ID = v.pc; rdata1_ID = v.pc * 3; rdata2_ID = ~v.pc;
        imm_ID = v.pc + 4; alu_op_ID = v.pc[3:2];
        #1;
        chk($sformatf("stall pc=%h", v.pc), stall_IF_ID, v.e_stall);
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("valid", valid_ID_EXE, e.e_valid);
        chk("rd", Rd_ID_EXE, e.e_rd);
        chk("reg_write", reg_write_ID_EXE, e.e_rw);
        chk("mem_read", mem_read_ID_EXE, e.e_mr);
        chk("mw_br_jmp", {mem_write_ID_EXE, branch_ID_EXE, jump_ID_EXE}, e.e_misc);
        if (e.e_valid) begin
            chk("rs1", Rs1_ID_EXE, e.e_rs1);
            chk("rs2", Rs2_ID_EXE, e.e_rs2);
            chk("pc", pc_ID_EXE, e.e_pc);
            chk("rdata1", rdata1_ID_EXE, e.e_pc * 3);
            chk("rdata2", rdata2_ID_EXE, ~e.e_pc);
            chk("imm", imm_ID_EXE, e.e_pc + 4);
            chk("alu_op", alu_op_ID_EXE, e.e_pc[3:2]);
            chk("mem_2_reg", mem_2_reg_ID_EXE, e.e_mr);
            chk("alu_src", alu_src_ID_EXE, e.e_asrc);
        end
`ifdef ID_EXE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, e.e_sc);
        chk("flush_cnt", flush_cnt, e.e_fc);
`endif
    endtask

    initial begin
        vec_t ld;
        vec_t a;
        tv.push_back(bub(ctl(op(0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0), 0, 0, 0));
        tv.push_back(cap(lw(5, 'h100), 0, 0, 0));
        tv.push_back(bub(op(5, 7, 6, 1, 1, 0, 'h104), 1, 1, 0));
        tv.push_back(cap(op(5, 7, 6, 1, 1, 0, 'h104), 0, 1, 0));
        tv.push_back(cap(lw(0, 'h108), 0, 1, 0));
        tv.push_back(cap(op(0, 7, 6, 1, 1, 0, 'h10c), 0, 1, 0));
        tv.push_back(cap(lw(5, 'h110), 0, 1, 0));
        tv.push_back(cap(op(8, 5, 6, 0, 1, 0, 'h114), 0, 1, 0));
        tv.push_back(cap(lw(5, 'h118), 0, 1, 0));
        tv.push_back(bub(op(9, 5, 0, 1, 0, 3'b100, 'h11c), 1, 2, 0));
        tv.push_back(cap(op(9, 5, 0, 1, 0, 3'b100, 'h11c), 0, 2, 0));
        tv.push_back(cap(lw(5, 'h120), 0, 2, 0));
        tv.push_back(cap(ctl(op(5, 6, 0, 1, 0, 3'b010, 'h124), 0, 0, 0, 0), 0, 2, 0));
        tv.push_back(cap(lw(5, 'h128), 0, 2, 0));
        tv.push_back(bub(ctl(op(5, 7, 6, 1, 1, 0, 'h12c), 0, 0, 1, 1), 0, 2, 1));
        tv.push_back(cap(op(5, 7, 6, 1, 1, 0, 'h130), 0, 2, 1));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i]);
        end

        // hold over a pending load-use: frozen, then exactly one bubble
        ld = cap(lw(5, 'h134), 0, 2, 1);
        step(ld);
        a = op(5, 7, 6, 1, 1, 0, 'h138);
        for (int k = 0; k < 3; k++) begin
            step(frz(ctl(a, 0, 1, 0, 1), ld, 1, 2, 1));
        end
        step(bub(a, 1, 3, 1));
        step(cap(a, 0, 3, 1));

        // reset in the middle of a stall leaves nothing behind
        step(cap(lw(5, 'h13c), 0, 3, 1));
        step(bub(ctl(op(5, 7, 6, 1, 1, 0, 'h140), 1, 0, 0, 1), 0, 0, 0));
        step(cap(op(5, 7, 6, 1, 1, 0, 'h140), 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
